spi_slave_regfile: RTL and testbench

SPI responder that sits on the far end of the team's APB SPI master bus (master `spi_sdo0` to `spi_mosi`, `spi_sdi0` from `spi_miso`, one `spi_csnX` to `spi_csn`). It exposes a byte-wide register file to the SPI master. Each transaction is a command byte followed by burst read or write data bytes with address auto-increment. All SPI inputs are oversampled in the `HCLK` domain, so the block is fully synchronous and replaces the behavioural slave simulator in system benches.

---
 rtl/spi_slave_regfile.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile
//   SPI mode-0 responder exposing a byte-wide register file. Every SPI pin is
//   oversampled in the HCLK domain, so all logic is synchronous to HCLK.
//   A transaction is a command byte (bit7 = read, low AW bits = start address)
//   followed by a burst of data bytes with address auto-increment.
//
// Ports
//   HCLK, HRESET          system clock, synchronous active-high reset
//   spi_clk/csn/mosi      SPI pins from the master (asynchronous)
//   spi_miso, spi_miso_oe serial data to the master and its output enable
//   wr_valid_o/addr/data  one-cycle report of each register written over SPI
//   rd_addr_i, rd_data_o  local combinational read port
//   busy_o                synchronised chip select active
module spi_slave_regfile #(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] ID_BYTE = 8'hA5,
  localparam int        AW      = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          spi_clk,
  input  logic          spi_csn,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state_q, state_d;
  logic          sclk_p0, sclk_p1, sclk_p2;
  logic          csn_p0, csn_p1, csn_p2;
  logic          mosi_p0, mosi_p1;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sr;
  logic [7:0]    tx_sr;
  logic          byte_done;
  logic          rd_mode;
  logic [AW-1:0] addr;
  logic [7:0]    regs [DEPTH];

  logic          sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]    rx_byte;

  // Synchroniser stage: p0/p1 resolve metastability, p2 is edge history.
  // Chip-select flops reset to the inactive (high) level so no transaction
  // is seen and busy/oe stay low during reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      csn_p0  <= 1'b1;
      csn_p1  <= 1'b1;
      csn_p2  <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= spi_clk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      csn_p0  <= spi_csn;
      csn_p1  <= csn_p0;
      csn_p2  <= csn_p1;
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  // Edge-detect stage
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_fall   = ~csn_p1 & csn_p2;
  assign cs_rise   = csn_p1 & ~csn_p2;
  assign rx_byte   = {rx_sr[6:0], mosi_p1};

  assign busy_o      = ~csn_p2;
  assign spi_miso_oe = ~csn_p2;
  assign rd_data_o   = regs[rd_addr_i];

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_rise)                             state_d = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7)   state_d = DATA;
      end
      DATA:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Action stage: shift registers, register file and write report.
  // cs_rise wins over any SPI clock edge in the same cycle, which also
  // discards a partially received byte.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bit_cnt    <= 3'd0;
      rx_sr      <= 8'h00;
      tx_sr      <= 8'h00;
      byte_done  <= 1'b0;
      rd_mode    <= 1'b0;
      addr       <= '0;
      spi_miso   <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_valid_o <= 1'b0;
      spi_miso   <= tx_sr[7];
      if (cs_fall) begin
        bit_cnt   <= 3'd0;
        rx_sr     <= 8'h00;
        tx_sr     <= ID_BYTE;
        byte_done <= 1'b0;
      end else if (cs_rise) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
      end else if (state_q != IDLE) begin
        if (sclk_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            if (state_q == CMD) begin
              rd_mode <= rx_byte[7];
              addr    <= rx_byte[AW-1:0];
            end else if (!rd_mode) begin
              regs[addr] <= rx_byte;
              wr_valid_o <= 1'b1;
              wr_addr_o  <= addr;
              wr_data_o  <= rx_byte;
              addr       <= addr + 1'b1;
            end
          end
        end else if (sclk_fall) begin
          // First fall after a completed byte loads the next TX byte;
          // a read advances the address as each byte is fetched.
          if (byte_done) begin
            byte_done <= 1'b0;
            if (rd_mode) begin
              tx_sr <= regs[addr];
              addr  <= addr + 1'b1;
            end else begin
              tx_sr <= 8'h00;
            end
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile
//   Directed bench: an SPI master model drives write/read bursts, an aborted
//   transaction, address masking and a mid-byte reset at two timings. Expected
//   writes and MISO bytes are queued when issued; a monitor pops and compares.
module tb_spi_slave_regfile;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic [7:0]    rd_data_o;
  logic          busy_o;

  spi_slave_regfile #(.DEPTH(DEPTH), .ID_BYTE(8'hA5)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  int half  = 8;
  int gap   = 8;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  act_miso[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (half=%0d)", name, act, exp, half);
    end
  endtask

  // Scoreboard monitor
  always @(negedge HCLK) begin
    if (!HRESET && wr_valid_o) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", {20'd0, wr_addr_o, wr_data_o}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", {20'd0, wr_addr_o, wr_data_o}, {20'd0, exp_wr.pop_front()});
      end
    end
    while (act_miso.size() > 0 && exp_miso.size() > 0)
      check("miso_byte", {24'd0, act_miso.pop_front()}, {24'd0, exp_miso.pop_front()});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      tick(half);
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      tick(half);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] r;
    exp_miso.push_back(exp);
    xfer_bits(tx, 8, r);
    act_miso.push_back(r);
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    tick(half);
  endtask

  task automatic cs_high();
    tick(half);
    spi_csn = 1'b1;
    tick(gap);
  endtask

  task automatic check_rd(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    rd_addr_i = a;
    #1;
    check(name, {24'd0, rd_data_o}, {24'd0, exp});
  endtask

  task automatic run_all();
    logic [7:0] r;
    // Reset state
    HRESET = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    tick(4);
    check("rst_outputs", {26'd0, spi_miso, spi_miso_oe, wr_valid_o, busy_o, |wr_addr_o, |wr_data_o}, 32'd0);
    for (int a = 0; a < DEPTH; a++) check_rd("rst_rd_data", a[AW-1:0], 8'h00);
    HRESET = 1'b0;
    tick(4);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Write burst from address 2
    exp_wr.push_back({4'd2, 8'h11});
    exp_wr.push_back({4'd3, 8'h22});
    exp_wr.push_back({4'd4, 8'h33});
    cs_low();
    check("busy_active", {30'd0, busy_o, spi_miso_oe}, 32'd3);
    send(8'h02, 8'hA5); send(8'h11, 8'h00); send(8'h22, 8'h00); send(8'h33, 8'h00);
    cs_high();
    check_rd("wr_rd2", 4'd2, 8'h11);
    check_rd("wr_rd3", 4'd3, 8'h22);
    check_rd("wr_rd4", 4'd4, 8'h33);

    // Preload 14, 15, 0 (wrapping write), then read burst with wrap
    exp_wr.push_back({4'd14, 8'hDE});
    exp_wr.push_back({4'd15, 8'hAD});
    exp_wr.push_back({4'd0,  8'hBE});
    cs_low();
    send(8'h0E, 8'hA5); send(8'hDE, 8'h00); send(8'hAD, 8'h00); send(8'hBE, 8'h00);
    cs_high();
    check_rd("preload_rd0", 4'd0, 8'hBE);
    cs_low();
    send(8'h8E, 8'hA5); send(8'h00, 8'hDE); send(8'h00, 8'hAD); send(8'h00, 8'hBE);
    cs_high();

    // Aborted write: 5 data bits then CS rises
    cs_low();
    send(8'h05, 8'hA5);
    xfer_bits(8'hFF, 5, r);
    cs_high();
    check_rd("abort_rd5", 4'd5, 8'h00);

    // Address masking: 0x7F targets register 15
    exp_wr.push_back({4'd15, 8'h5A});
    cs_low();
    send(8'h7F, 8'hA5); send(8'h5A, 8'h00);
    cs_high();
    check_rd("mask_rd15", 4'd15, 8'h5A);
    check_rd("mask_rd14", 4'd14, 8'hDE);

    // Reset in the middle of a data byte
    cs_low();
    send(8'h03, 8'hA5);
    xfer_bits(8'h77, 4, r);
    HRESET = 1'b1;
    tick(2);
    check("midrst_outputs", {29'd0, spi_miso, wr_valid_o, busy_o}, 32'd0);
    HRESET = 1'b0;
    xfer_bits(8'h70, 4, r);
    cs_high();
    check_rd("midrst_rd3", 4'd3, 8'h00);
    check_rd("midrst_rd15", 4'd15, 8'h00);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    cs_low();
    send(8'h80, 8'hA5); send(8'h00, 8'h00);
    cs_high();
    tick(4);
  endtask

  initial begin
    half = 8; gap = 8;
    run_all();
    half = 6; gap = 4;
    run_all();
    tick(10);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("miso_queue_drained", exp_miso.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
